johnson_counter_param: RTL and testbench

Parametrised, bidirectional Johnson (twisted-ring) counter. It generalises the fixed 4-bit Johnson counter with these additions:
- configurable width
- count enable and direction control
- synchronous parallel load
- binary state index and wrap pulse
- detection of and recovery from illegal codes

It serves as a glitch-free sequence/phase generator for timing and sequencing logic elsewhere in the design.

---
 rtl/johnson_pkg.sv | 35 +++
 rtl/johnson_decode.sv | 17 +
 rtl/johnson_counter_param.sv | 95 +++++++++
 tb/tb_johnson_counter_param.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson counter: code validation and code-to-index mapping.
package johnson_pkg;

   localparam int MAX_WIDTH = 16;
   localparam int MAX_IDX_W = $clog2(2 * MAX_WIDTH);

   function automatic logic [MAX_WIDTH-1:0] johnson_ones(input int n);
      logic [MAX_WIDTH:0] m;
      m = ({{MAX_WIDTH{1'b0}}, 1'b1} << n) - 1'b1;
      return m[MAX_WIDTH-1:0];
   endfunction

   // Loops run to MAX_WIDTH with a guard so the bounds stay constant.
   function automatic logic johnson_is_valid(input logic [MAX_WIDTH-1:0] code, input int width);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k <= MAX_WIDTH; k++)
         if (k <= width && code == johnson_ones(k)) ok = 1'b1;
      for (int j = 1; j < MAX_WIDTH; j++)
         if (j < width && code == (johnson_ones(width) & ~johnson_ones(width - j))) ok = 1'b1;
      return ok;
   endfunction

   function automatic logic [MAX_IDX_W-1:0] johnson_to_idx(input logic [MAX_WIDTH-1:0] code, input int width);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int k = 0; k <= MAX_WIDTH; k++)
         if (k <= width && code == johnson_ones(k)) idx = MAX_IDX_W'(k);
      for (int j = 1; j < MAX_WIDTH; j++)
         if (j < width && code == (johnson_ones(width) & ~johnson_ones(width - j)))
            idx = MAX_IDX_W'(2 * width - j);
      return idx;
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// One-hot decoder from the Johnson index to a 2*WIDTH-bit phase vector.
module johnson_decode #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [IDX_W-1:0] idx,
   output logic [N-1:0]     dec
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         assign dec[gi] = (idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/johnson_counter_param.sv
// Bidirectional Johnson counter with load, binary index, wrap and illegal-code recovery.
// Define JOHNSON_DECODE_EN to drive dec with a one-hot decode of idx; otherwise dec is zero.
module johnson_counter_param
   import johnson_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int IDX_W = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               dir,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   output logic [WIDTH-1:0]   q,
   output logic [IDX_W-1:0]   idx,
   output logic               wrap,
   output logic               err,
   output logic [2*WIDTH-1:0] dec
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] LSB_ONLY = WIDTH'(1);

   logic [WIDTH-1:0] q_reg, q_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             err_reg, err_next;
   logic             q_valid, load_valid;
   logic [IDX_W-1:0] load_idx;

   assign q_valid    = johnson_is_valid(MAX_WIDTH'(q_reg), WIDTH);
   assign load_valid = johnson_is_valid(MAX_WIDTH'(load_val), WIDTH);
   assign load_idx   = IDX_W'(johnson_to_idx(MAX_WIDTH'(load_val), WIDTH));

   // Load beats recovery; a corrupt ring is cleared even when counting is disabled.
   always_comb begin
      q_next   = q_reg;
      idx_next = idx_reg;
      err_next = 1'b0;
      if (load) begin
         if (load_valid) begin
            q_next   = load_val;
            idx_next = load_idx;
         end else begin
            q_next   = '0;
            idx_next = '0;
            err_next = 1'b1;
         end
      end else if (!q_valid) begin
         q_next   = '0;
         idx_next = '0;
         err_next = 1'b1;
      end else if (en) begin
         if (!dir) begin
            q_next   = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
         end else begin
            q_next   = {~q_reg[0], q_reg[WIDTH-1:1]};
            idx_next = (idx_reg == '0) ? LAST_IDX : idx_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         q_reg   <= '0;
         idx_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         q_reg   <= q_next;
         idx_reg <= idx_next;
         err_reg <= err_next;
      end
   end

   assign q    = q_reg;
   assign idx  = idx_reg;
   assign err  = err_reg;
   assign wrap = en & ~load & reset & q_valid &
                 ((~dir & (q_reg == MSB_ONLY)) | (dir & (q_reg == LSB_ONLY)));

`ifdef JOHNSON_DECODE_EN
   johnson_decode #(
      .N     (2 * WIDTH),
      .IDX_W (IDX_W)
   ) u_decode (
      .idx (idx_reg),
      .dec (dec)
   );
`else
   assign dec = '0;
`endif

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: WIDTH=4 behaviour plus a WIDTH=5 decode check.
module tb_johnson_counter_param;

   logic       clk = 1'b0;
   logic       reset, en, dir, load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic [2:0] idx;
   logic       wrap, err;
   logic [7:0] dec;

   logic       reset5, en5, dir5, load5;
   logic [4:0] load_val5;
   logic [4:0] q5;
   logic [3:0] idx5;
   logic       wrap5, err5;
   logic [9:0] dec5;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   johnson_counter_param #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .q(q), .idx(idx), .wrap(wrap), .err(err), .dec(dec)
   );

   johnson_counter_param #(.WIDTH(5)) dut5 (
      .clk(clk), .reset(reset5), .en(en5), .dir(dir5), .load(load5), .load_val(load_val5),
      .q(q5), .idx(idx5), .wrap(wrap5), .err(err5), .dec(dec5)
   );

   function automatic logic [31:0] exp_dec(input int i);
`ifdef JOHNSON_DECODE_EN
      return 32'(1) << i;
`else
      return 32'(i) & 32'h0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] fwd_seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   logic [3:0] rev_q   [4] = '{4'h3, 4'h1, 4'h0, 4'h8};
   logic [2:0] rev_idx [4] = '{3'd2, 3'd1, 3'd0, 3'd7};
   logic       rev_wrap[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;
      reset5 = 1'b0; en5 = 1'b0; dir5 = 1'b0; load5 = 1'b0; load_val5 = 5'h0;

      // Reset state
      step(); step();
      check("reset_q", 32'(q), 32'h0);
      check("reset_idx", 32'(idx), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      check("reset_dec", 32'(dec), exp_dec(0));

      // Forward full cycle
      reset = 1'b1; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         check($sformatf("fwd_wrap_%0d", i), 32'(wrap), 32'(fwd_seq[i % 8] == 4'h8));
         step();
         check($sformatf("fwd_q_%0d", i), 32'(q), 32'(fwd_seq[(i + 1) % 8]));
         check($sformatf("fwd_idx_%0d", i), 32'(idx), 32'((i + 1) % 8));
      end

      // Advance to 0111 then reverse through the zero wrap
      step(); step();
      check("pre_rev_q", 32'(q), 32'h7);
      check("pre_rev_idx", 32'(idx), 32'd3);
      dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rev_wrap_%0d", i), 32'(wrap), 32'(rev_wrap[i]));
         step();
         check($sformatf("rev_q_%0d", i), 32'(q), 32'(rev_q[i]));
         check($sformatf("rev_idx_%0d", i), 32'(idx), 32'(rev_idx[i]));
      end

      // Load valid then invalid; q=1000 fwd would wrap but load masks it
      dir = 1'b0; load = 1'b1; load_val = 4'hC;
      #1;
      check("load_wrap_masked", 32'(wrap), 32'h0);
      step();
      check("load_valid_q", 32'(q), 32'hC);
      check("load_valid_idx", 32'(idx), 32'd6);
      check("load_valid_err", 32'(err), 32'h0);
      load_val = 4'h5;
      step();
      check("load_bad_q", 32'(q), 32'h0);
      check("load_bad_idx", 32'(idx), 32'h0);
      check("load_bad_err", 32'(err), 32'h1);
      load = 1'b0; en = 1'b0;
      step();
      check("load_bad_err_clr", 32'(err), 32'h0);

      // Hold with en=0, then reset overrides load/en
      load = 1'b1; load_val = 4'h7;
      step();
      check("load_7_idx", 32'(idx), 32'd3);
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold_q_%0d", i), 32'(q), 32'h7);
         check($sformatf("hold_idx_%0d", i), 32'(idx), 32'd3);
         check($sformatf("hold_wrap_%0d", i), 32'(wrap), 32'h0);
      end
      reset = 1'b0; load = 1'b1; en = 1'b1; load_val = 4'h3;
      step();
      check("rst_over_q", 32'(q), 32'h0);
      check("rst_over_idx", 32'(idx), 32'h0);
      reset = 1'b1; load = 1'b0; en = 1'b0;

      // Illegal state recovery
      force dut4.q_reg = 4'hA;
      #1;
      release dut4.q_reg;
      step();
      check("illegal_q", 32'(q), 32'h0);
      check("illegal_idx", 32'(idx), 32'h0);
      check("illegal_err", 32'(err), 32'h1);
      en = 1'b1;
      step();
      check("resume_q", 32'(q), 32'h1);
      check("resume_idx", 32'(idx), 32'd1);
      check("resume_err", 32'(err), 32'h0);
      step();
      check("resume2_q", 32'(q), 32'h3);

      // WIDTH=5 decode
      step();
      check("w5_reset_idx", 32'(idx5), 32'h0);
      check("w5_reset_dec", 32'(dec5), exp_dec(0));
      reset5 = 1'b1; en5 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("w5_idx_%0d", i), 32'(idx5), 32'((i + 1) % 10));
         check($sformatf("w5_dec_%0d", i), 32'(dec5), exp_dec((i + 1) % 10));
      end
      check("w5_q_wrapped", 32'(q5), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
